enc_edge_stamper: RTL
=====================

Name: enc_edge_stamper

Overview:
- Multi-channel edge timestamper for the encoder and IRIG inputs at the PL boundary of the Zynq system.
- Synchronises N_CH encoder lines plus one IRIG line and detects the configured edges on each.
- Tags each edge with a free-running timestamp and a per-channel edge count.
- Queues the records in a FIFO drained over an AXI-Stream-style master port to a DMA/readout path.

Parameters:
- N_CH, 2, number of encoder channels (1..126).
- TS_W, 32, timestamp counter width.
- ECNT_W, 16, per-channel edge counter width.
- FIFO_DEPTH, 16, record FIFO depth; power of 2, at least 4.
- SYNC_STAGES, 2, synchroniser flops per input; at least 2.
- EDGE_MODE, 0, 0 = rising, 1 = falling, 2 = both.
- FILT_LEN, 4, glitch-filter stable cycles; used only with ENC_GLITCH_FILTER_EN.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous active-high reset.
- enc_in  in  N_CH  asynchronous encoder lines.
- irig_in  in  1  asynchronous IRIG line; channel code 7'h7F.
- en  in  1  edge acceptance enable.
- m_tdata  out  TS_W+ECNT_W+8  record: [TS_W-1:0] timestamp, next ECNT_W edge count, [top] polarity, [top-1 : top-7] channel code.
- m_tvalid  out  1  record valid.
- m_tready  in  1  downstream accept.
- drop_cnt  out  16  saturating count of lost records.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset values:
  - Outputs: m_tvalid=0, m_tdata=0, drop_cnt=0, fifo_level=0.
  - Internal: timestamp counter=0, edge counters=0, sync flops=0, pending flags=0.
- Timestamp counter:
  - Increments every cycle regardless of en.
  - Wraps 2^TS_W-1 -> 0 silently.
- Arm period:
  - For the first SYNC_STAGES+1 cycles after rst deasserts, edge detection is suppressed.
  - No spurious edge from the reset level of the sync flops.
- Edge detect:
  - Compares the synchronised level with its previous value; edge type selected by EDGE_MODE.
  - Polarity bit = new level.
  - An accepted edge requires en=1.
- Latency (edge 0 = first clock edge sampling the new level, no backpressure):
  - Pending slot loaded at edge SYNC_STAGES.
  - FIFO written at edge SYNC_STAGES+1.
  - m_tvalid high after edge SYNC_STAGES+1.
  - Timestamp = counter value in the cycle between edges SYNC_STAGES-1 and SYNC_STAGES.
- Edge counter:
  - Per channel, increments on every accepted edge, including dropped ones.
  - Wraps modulo 2^ECNT_W.
  - Record carries the post-increment value; the first edge after reset reports 1.
- Pending slots:
  - One per channel (N_CH+1 total); each holds timestamp, count and polarity.
  - Per cycle, the lowest-index non-empty slot is written if the FIFO is not full; IRIG is lowest priority.
- Boundary conditions:
  - Edge on a channel whose slot is occupied and not draining this cycle: record lost, drop_cnt+1, saturating at 16'hFFFF.
  - Slot draining and new edge on the same cycle: slot reloaded with no loss.
  - FIFO full: writes stall and slots hold.
  - FIFO simultaneous read and write when full: both occur, level unchanged.
  - Output empty: m_tvalid=0.
- Stream protocol:
  - First-word-fall-through; transfer when m_tvalid && m_tready.
  - m_tdata is stable while m_tvalid=1 and m_tready=0.
- en deasserted: no new edges accepted; existing slots and FIFO continue to drain.
- rst mid-operation: immediate clear of FIFO, slots, counters and drop_cnt; arm period re-applied.

Optional Feature:
- Macro: ENC_GLITCH_FILTER_EN.
- Defined: each synchronised input passes a per-channel filter that updates its output only after the input holds a new level for FILT_LEN consecutive cycles.
  - Pulses shorter than FILT_LEN are ignored.
  - Latency increases by FILT_LEN cycles.
  - The arm period extends by FILT_LEN cycles.
- Undefined: the filter is absent; latency is as stated in Behaviour.

Test Plan:
- Rising edge: N_CH=2, EDGE_MODE=0, m_tready=1, single rising edge on enc_in[0] at counter 100 -> one record with ch=0, pol=1, count=1, ts=100+SYNC_STAGES-1; m_tvalid high for exactly one cycle.
- Both-edges mode: EDGE_MODE=2, pulse on enc_in[1], irig_in rises in the same cycle as enc_in[1] rises -> records in order ch1 rise, IRIG (7'h7F) with an identical ts, then ch1 fall; counts 1, 1, 2.
- Backpressure and drop: m_tready=0, 20 edges on ch0 with FIFO_DEPTH=16 -> fifo_level=16, 1 record in the slot, drop_cnt=3; after release, 17 records drain with counts 1..17; the last count is 20 minus the dropped edges' gaps visible.
- Enable and reset: en=0 during 5 edges -> no records, counter unchanged; rst asserted with 3 records queued -> m_tvalid=0, fifo_level=0 next cycle, no spurious edge with enc_in held high through release.
- Timestamp wrap: TS_W=8, edges at counters 254 and 258 -> reported ts 254 and 2.
- Glitch filter: with ENC_GLITCH_FILTER_EN and FILT_LEN=4, a 3-cycle pulse gives no record; a 5-cycle pulse gives one record, FILT_LEN cycles later than without the macro.

Source files
------------

// File: rtl/enc_edge_stamper.sv
// rtl/enc_edge_stamper.sv - multi-channel encoder/IRIG edge timestamper with record FIFO
//
// Synchronises N_CH encoder lines plus one IRIG line and detects the configured
// edges on each (EDGE_MODE 0 rising, 1 falling, 2 both). Each accepted edge is
// stamped with a free-running timestamp and a per-channel edge count. The record
// waits in a one-deep per-channel pending slot, then moves into a
// first-word-fall-through FIFO that is drained over a stream master port.
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   enc_in       asynchronous encoder lines, channel codes 0..N_CH-1
//   irig_in      asynchronous IRIG line, channel code 7'h7F
//   en           edge acceptance enable
//   m_tdata      record {polarity, channel[6:0], edge count, timestamp}
//   m_tvalid     record valid
//   m_tready     downstream accept
//   drop_cnt     saturating count of records lost to an occupied pending slot
//   fifo_level   current FIFO occupancy
//
// Optional feature: ENC_GLITCH_FILTER_EN adds a FILT_LEN-cycle stability filter
// after each synchroniser.
module enc_edge_stamper #(
  parameter int N_CH        = 2,
  parameter int TS_W        = 32,
  parameter int ECNT_W      = 16,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0,
  parameter int FILT_LEN    = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CH-1:0]             enc_in,
  input  logic                        irig_in,
  input  logic                        en,
  output logic [TS_W+ECNT_W+7:0]      m_tdata,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic [15:0]                 drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  // Channel N_CH is the IRIG line; it is also the lowest drain priority.
  localparam int NS = N_CH + 1;
  localparam int W  = TS_W + ECNT_W + 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(NS);
`ifdef ENC_GLITCH_FILTER_EN
  localparam bit FILT_ON = 1'b1;
`else
  localparam bit FILT_ON = 1'b0;
`endif
  // Detection stays off until the whole input pipeline holds post-reset samples.
  localparam int ARM_CYC = SYNC_STAGES + 1 + (FILT_ON ? FILT_LEN : 0);
  localparam int ARMW    = $clog2(ARM_CYC + 1);

  logic [NS-1:0]     sync_q [SYNC_STAGES];
  logic [NS-1:0]     lvl;
  logic [NS-1:0]     prev;
  logic [NS-1:0]     edge_hit;
  logic [NS-1:0]     accept;
  logic [ARMW-1:0]   arm_cnt;
  logic              armed;
  logic [TS_W-1:0]   ts;

  logic [NS-1:0]     slot_vld;
  logic [NS-1:0]     slot_pol;
  logic [TS_W-1:0]   slot_ts  [NS];
  logic [ECNT_W-1:0] slot_cnt [NS];
  logic [ECNT_W-1:0] ecnt     [NS];
  logic [NS-1:0]     drain;
  logic [NS-1:0]     lost;
  logic [7:0]        n_lost;
  logic [16:0]       drop_sum;

  logic [CW-1:0]     sel;
  logic [6:0]        code;
  logic [W-1:0]      wr_data;
  logic [W-1:0]      mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic [AW:0]       level;
  logic              full;
  logic              empty;
  logic              wr;
  logic              rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= {irig_in, enc_in};
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

`ifdef ENC_GLITCH_FILTER_EN
  localparam int FCW = $clog2(FILT_LEN + 1);
  logic [FCW-1:0] filt_cnt [NS];
  logic [NS-1:0]  filt_q;

  // Output follows the input only after FILT_LEN consecutive cycles at a new level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q <= '0;
      for (int i = 0; i < NS; i++) filt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NS; i++) begin
        if (sync_q[SYNC_STAGES-1][i] != filt_q[i]) begin
          if (filt_cnt[i] == FCW'(FILT_LEN - 1)) begin
            filt_q[i]   <= sync_q[SYNC_STAGES-1][i];
            filt_cnt[i] <= '0;
          end else begin
            filt_cnt[i] <= filt_cnt[i] + 1'b1;
          end
        end else begin
          filt_cnt[i] <= '0;
        end
      end
    end
  end
  assign lvl = filt_q;
`else
  assign lvl = sync_q[SYNC_STAGES-1];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ts      <= '0;
      prev    <= '0;
      arm_cnt <= '0;
    end else begin
      ts   <= ts + 1'b1;
      prev <= lvl;
      if (!armed) arm_cnt <= arm_cnt + 1'b1;
    end
  end
  assign armed = (arm_cnt == ARMW'(ARM_CYC));

  always_comb begin
    edge_hit = '0;
    case (EDGE_MODE)
      0:       edge_hit = lvl & ~prev;
      1:       edge_hit = ~lvl & prev;
      default: edge_hit = lvl ^ prev;
    endcase
    accept = (armed && en) ? edge_hit : '0;
  end

  // Lowest-index pending slot wins the FIFO write port.
  always_comb begin
    sel = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (slot_vld[i]) sel = CW'(i);
    end
  end

  assign level = wr_ptr - rd_ptr;
  assign full  = (level == (AW+1)'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign rd    = !empty && m_tready;
  // A read frees the full entry in the same cycle, so a write may proceed.
  assign wr    = (|slot_vld) && (!full || rd);

  assign code    = (sel == CW'(N_CH)) ? 7'h7F : 7'(sel);
  assign wr_data = {slot_pol[sel], code, slot_cnt[sel], slot_ts[sel]};

  always_comb begin
    drain  = '0;
    lost   = '0;
    n_lost = '0;
    for (int i = 0; i < NS; i++) begin
      drain[i] = wr && (sel == CW'(i));
      lost[i]  = accept[i] && slot_vld[i] && !drain[i];
      n_lost   = n_lost + 8'(lost[i]);
    end
    drop_sum = {1'b0, drop_cnt} + {9'd0, n_lost};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld <= '0;
      slot_pol <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < NS; i++) begin
        slot_ts[i]  <= '0;
        slot_cnt[i] <= '0;
        ecnt[i]     <= '0;
      end
    end else begin
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      for (int i = 0; i < NS; i++) begin
        // The counter advances even when the record itself is lost.
        if (accept[i]) ecnt[i] <= ecnt[i] + 1'b1;
        if (accept[i] && (!slot_vld[i] || drain[i])) begin
          slot_vld[i] <= 1'b1;
          slot_ts[i]  <= ts;
          slot_cnt[i] <= ecnt[i] + 1'b1;
          slot_pol[i] <= lvl[i];
        end else if (drain[i]) begin
          slot_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  assign m_tvalid   = !empty;
  assign m_tdata    = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign fifo_level = level;

endmodule
